// File: rtl/sdp_arb_pkg.sv
// Shared types and helpers for the simple-dual-port RAM arbiter.
package sdp_arb_pkg;

  localparam int RD_LAT_MAX = 3;

  typedef struct packed {
    logic       vld;
    logic [2:0] idx;
  } rsp_tag_t;

  // Round-robin pick: first set bit of req searching from ptr+1 (mod n), wrapping.
  function automatic logic [2:0] rr_pick(input logic [7:0]  req,
                                         input logic [2:0]  ptr,
                                         input int unsigned n);
    logic       found;
    logic [2:0] idx;
    rr_pick = ptr;
    found   = 1'b0;
    for (int unsigned k = 1; k <= 8; k++) begin
      idx = 3'((32'(ptr) + k) % n);
      if (k <= n && !found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a registered last-winner pointer; en gates grants without
// disturbing the candidate index.
module rr_arbiter
  import sdp_arb_pkg::*;
#(
  parameter int unsigned NREQ = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [2:0]      gnt_idx
);

  logic [2:0] r_ptr;
  logic [7:0] w_req;

  assign w_req   = 8'(req);
  assign gnt_idx = rr_pick(w_req, r_ptr, NREQ);

  always_comb begin
    gnt = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      gnt[i] = !rst && en && req[i] && (gnt_idx == 3'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= 3'(NREQ - 1);
    end else if (|gnt) begin
      r_ptr <= gnt_idx;
    end
  end

endmodule

// File: rtl/sdp_ram_arbiter.sv
// Shares one simple-dual-port RAM between NREQ requesters with independent write/read
// round-robin arbitration. Optional same-cycle RAW hold: SDP_ARB_RAW_HOLD_EN.
module sdp_ram_arbiter
  import sdp_arb_pkg::*;
#(
  parameter int unsigned NREQ   = 2,
  parameter int unsigned AW     = 4,
  parameter int unsigned DW     = 4,
  parameter int unsigned RD_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    wr_valid,
  input  logic [NREQ*AW-1:0] wr_addr,
  input  logic [NREQ*DW-1:0] wr_data,
  output logic [NREQ-1:0]    wr_ready,
  input  logic [NREQ-1:0]    rd_valid,
  input  logic [NREQ*AW-1:0] rd_addr,
  output logic [NREQ-1:0]    rd_ready,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [DW-1:0]      rsp_data,
  output logic               wea,
  output logic [AW-1:0]      addra,
  output logic [DW-1:0]      dina,
  output logic               reb,
  output logic [AW-1:0]      addrb,
  input  logic [DW-1:0]      doutb
);

  logic [NREQ-1:0] w_wr_gnt, w_rd_gnt;
  logic [2:0]      w_wr_idx, w_rd_idx;
  logic [AW-1:0]   w_wr_addr, w_rd_addr;
  logic [DW-1:0]   w_wr_data;
  logic            w_rd_en;

  rr_arbiter #(.NREQ(NREQ)) u_wr_arb (
    .clk     (clk),
    .rst     (rst),
    .en      (1'b1),
    .req     (wr_valid),
    .gnt     (w_wr_gnt),
    .gnt_idx (w_wr_idx)
  );

  rr_arbiter #(.NREQ(NREQ)) u_rd_arb (
    .clk     (clk),
    .rst     (rst),
    .en      (w_rd_en),
    .req     (rd_valid),
    .gnt     (w_rd_gnt),
    .gnt_idx (w_rd_idx)
  );

  always_comb begin
    w_wr_addr = '0;
    w_wr_data = '0;
    w_rd_addr = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (w_wr_idx == 3'(i)) begin
        w_wr_addr = wr_addr[i*AW +: AW];
        w_wr_data = wr_data[i*DW +: DW];
      end
      if (w_rd_idx == 3'(i)) begin
        w_rd_addr = rd_addr[i*AW +: AW];
      end
    end
  end

`ifdef SDP_ARB_RAW_HOLD_EN
  // Hold the read winner one cycle so it observes the write granted alongside it.
  assign w_rd_en = !((|w_wr_gnt) && (|rd_valid) && (w_rd_addr == w_wr_addr));
`else
  assign w_rd_en = 1'b1;
`endif

  logic          r_wea, r_reb;
  logic [AW-1:0] r_addra, r_addrb;
  logic [DW-1:0] r_dina;
  logic [2:0]    r_rb_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wea    <= 1'b0;
      r_addra  <= '0;
      r_dina   <= '0;
      r_reb    <= 1'b0;
      r_addrb  <= '0;
      r_rb_idx <= '0;
    end else begin
      r_wea <= |w_wr_gnt;
      if (|w_wr_gnt) begin
        r_addra <= w_wr_addr;
        r_dina  <= w_wr_data;
      end
      r_reb <= |w_rd_gnt;
      if (|w_rd_gnt) begin
        r_addrb  <= w_rd_addr;
        r_rb_idx <= w_rd_idx;
      end
    end
  end

  // Tags ride alongside the RAM read latency so data and owner line up at the output.
  rsp_tag_t r_pipe [RD_LAT];
  rsp_tag_t w_rsp_tag;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < RD_LAT; k++) begin
        r_pipe[k] <= '0;
      end
    end else begin
      r_pipe[0] <= {r_reb, r_rb_idx};
      for (int unsigned k = 1; k < RD_LAT; k++) begin
        r_pipe[k] <= r_pipe[k-1];
      end
    end
  end

  assign w_rsp_tag = r_pipe[RD_LAT-1];

  always_comb begin
    rsp_valid = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      rsp_valid[i] = !rst && w_rsp_tag.vld && (w_rsp_tag.idx == 3'(i));
    end
  end

  assign rsp_data = (!rst && w_rsp_tag.vld) ? doutb : '0;
  assign wr_ready = w_wr_gnt;
  assign rd_ready = w_rd_gnt;
  assign wea      = r_wea;
  assign addra    = r_addra;
  assign dina     = r_dina;
  assign reb      = r_reb;
  assign addrb    = r_addrb;

endmodule

// File: tb/tb_sdp_ram_arbiter.sv
// Directed bench for sdp_ram_arbiter with a behavioural 1-cycle-latency SDP RAM.
module tb_sdp_ram_arbiter;

  localparam int unsigned NREQ   = 2;
  localparam int unsigned AW     = 4;
  localparam int unsigned DW     = 4;
  localparam int unsigned RD_LAT = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst;
  logic [NREQ-1:0]    wr_valid, wr_ready, rd_valid, rd_ready, rsp_valid;
  logic [NREQ*AW-1:0] wr_addr, rd_addr;
  logic [NREQ*DW-1:0] wr_data;
  logic [DW-1:0]      rsp_data, dina;
  logic [AW-1:0]      addra, addrb;
  logic               wea, reb;
  logic [DW-1:0]      doutb = '0;

  int n_checks = 0;
  int n_errors = 0;

  sdp_ram_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_valid  (wr_valid),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready),
    .rd_valid  (rd_valid),
    .rd_addr   (rd_addr),
    .rd_ready  (rd_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .wea       (wea),
    .addra     (addra),
    .dina      (dina),
    .reb       (reb),
    .addrb     (addrb),
    .doutb     (doutb)
  );

  // RAM model: both ports on clk, read returns pre-write contents on collision.
  logic [DW-1:0] mem [16];
  logic          mem_init = 1'b0;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 16; i++) mem[i] <= '0;
      mem_init <= 1'b1;
    end else begin
      if (wea) mem[addra] <= dina;
      if (reb) doutb <= mem[addrb];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  int cnt0, cnt1, w, a0, a1;
  int pend_w [18];
  int pend_a [18];

  initial begin
    rst      = 1'b1;
    wr_valid = 2'b11;
    rd_valid = 2'b11;
    wr_addr  = '0;
    wr_data  = '0;
    rd_addr  = '0;

    // Reset with every valid asserted: all outputs quiet.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      check("rst_wr_ready", 32'(wr_ready), 32'h0);
      check("rst_rd_ready", 32'(rd_ready), 32'h0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      check("rst_rsp_data", 32'(rsp_data), 32'h0);
      check("rst_wea", 32'(wea), 32'h0);
      check("rst_reb", 32'(reb), 32'h0);
      check("rst_addra", 32'(addra), 32'h0);
      check("rst_dina", 32'(dina), 32'h0);
      check("rst_addrb", 32'(addrb), 32'h0);
    end

    // Write contention filling addr i with i+1; one read of addr F on the first cycle.
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      rst      = 1'b0;
      a0       = k + (k % 2);
      a1       = k + 1 - (k % 2);
      wr_addr  = {4'(a1), 4'(a0)};
      wr_data  = {4'(a1 + 1), 4'(a0 + 1)};
      rd_valid = (k == 0) ? 2'b11 : 2'b00;
      rd_addr  = 8'hFF;
      #1;
      check("wr_ready_alt", 32'(wr_ready), (k % 2 == 0) ? 32'h1 : 32'h2);
      check("wea_run", 32'(wea), (k == 0) ? 32'h0 : 32'h1);
      if (k > 0) begin
        check("addra_run", 32'(addra), 32'(k - 1));
        check("dina_run", 32'(dina), 32'(k));
      end
      if (k == 0) check("first_rd_ready", 32'(rd_ready), 32'h1);
      if (k == 1) begin
        check("first_reb", 32'(reb), 32'h1);
        check("first_addrb", 32'(addrb), 32'hF);
      end
      if (k == 2) begin
        check("first_rsp_valid", 32'(rsp_valid), 32'h1);
        check("first_rsp_data", 32'(rsp_data), 32'h0);
      end
    end
    @(negedge clk);
    wr_valid = 2'b00;
    #1;
    check("wea_last", 32'(wea), 32'h1);
    check("addra_last", 32'(addra), 32'h7);
    check("dina_last", 32'(dina), 32'h8);
    check("wr_ready_idle", 32'(wr_ready), 32'h0);
    @(negedge clk); #1;
    check("wea_off", 32'(wea), 32'h0);
    check("addra_hold", 32'(addra), 32'h7);

    // Readback by both requesters, interleaved; requester 1 leads since rptr=0.
    cnt0 = 0;
    cnt1 = 0;
    for (int j = 0; j < 18; j++) begin
      @(negedge clk);
      rd_valid = (j < 16) ? 2'b11 : 2'b00;
      rd_addr  = {4'(cnt1), 4'(cnt0)};
      #1;
      if (j < 16) begin
        w = (j % 2 == 0) ? 1 : 0;
        check("rb_rd_ready", 32'(rd_ready), (w == 1) ? 32'h2 : 32'h1);
        pend_w[j] = w;
        pend_a[j] = (w == 1) ? cnt1 : cnt0;
        if (w == 1) cnt1++;
        else cnt0++;
      end
      if (j >= 2) begin
        check("rb_rsp_valid", 32'(rsp_valid), (pend_w[j-2] == 1) ? 32'h2 : 32'h1);
        check("rb_rsp_data", 32'(rsp_data), 32'(pend_a[j-2] + 1));
      end else begin
        check("rb_rsp_idle", 32'(rsp_valid), 32'h0);
      end
    end

    // Lone requester 1 gets a grant every cycle.
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      rd_valid = (j < 6) ? 2'b10 : 2'b00;
      rd_addr  = {4'(j), 4'h0};
      #1;
      if (j < 6) check("solo_rd_ready", 32'(rd_ready), 32'h2);
      if (j >= 2) begin
        check("solo_rsp_valid", 32'(rsp_valid), 32'h2);
        check("solo_rsp_data", 32'(rsp_data), 32'(j - 1));
      end
    end

    // Reset one cycle after a read handshake drops the response.
    @(negedge clk);
    rd_valid = 2'b01;
    rd_addr  = {4'h0, 4'h3};
    #1;
    check("rr_rd_ready", 32'(rd_ready), 32'h1);
    @(negedge clk);
    rd_valid = 2'b00;
    rst      = 1'b1;
    #1;
    check("rr_reb_inflight", 32'(reb), 32'h1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rr_no_rsp", 32'(rsp_valid), 32'h0);
      check("rr_reb_off", 32'(reb), 32'h0);
    end

    // Same-cycle write and read of addr 5 (old contents 6, new data 9).
    @(negedge clk);
    wr_valid = 2'b01;
    wr_addr  = {4'h0, 4'h5};
    wr_data  = {4'h0, 4'h9};
    rd_valid = 2'b01;
    rd_addr  = {4'h0, 4'h5};
    #1;
    check("raw_wr_ready", 32'(wr_ready), 32'h1);
`ifdef SDP_ARB_RAW_HOLD_EN
    check("raw_rd_held", 32'(rd_ready), 32'h0);
    @(negedge clk);
    wr_valid = 2'b00;
    #1;
    check("raw_rd_retry", 32'(rd_ready), 32'h1);
    @(negedge clk);
    rd_valid = 2'b00;
    #1;
    check("raw_rsp_early", 32'(rsp_valid), 32'h0);
    @(negedge clk); #1;
    check("raw_rsp_valid", 32'(rsp_valid), 32'h1);
    check("raw_rsp_data", 32'(rsp_data), 32'h9);
`else
    check("raw_rd_ready", 32'(rd_ready), 32'h1);
    @(negedge clk);
    wr_valid = 2'b00;
    rd_valid = 2'b00;
    #1;
    check("raw_rsp_early", 32'(rsp_valid), 32'h0);
    @(negedge clk); #1;
    check("raw_rsp_valid", 32'(rsp_valid), 32'h1);
    check("raw_rsp_data", 32'(rsp_data), 32'h6);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sdp_ram_arbiter.md
# sdp_ram_arbiter

Single-clock round-robin arbiter that shares one simple-dual-port RAM (`sdp_two_clk`, both clocks tied to `clk`) between `NREQ` requesters. The write port and the read port are arbitrated independently, one grant per port per cycle. Read data is returned to the requester that issued the read. The block sits between client engines and the RAM instance; the RAM itself stays outside.

## Interface
Parameters:
- `NREQ`, 2 — number of requesters, 2..8.
- `AW`, 4 — RAM address width.
- `DW`, 4 — RAM data width.
- `RD_LAT`, 1 — RAM read latency in cycles from `reb`/`addrb` sampled to `doutb` valid; 1..3.

Ports:
- `clk` in 1 — single clock for the arbiter and both RAM ports.
- `rst` in 1 — synchronous, active-high reset.
- `wr_valid` in NREQ — per-requester write request.
- `wr_addr` in NREQ*AW — packed write addresses; requester i occupies bits [i*AW +: AW].
- `wr_data` in NREQ*DW — packed write data.
- `wr_ready` out NREQ — one-hot write grant (combinational).
- `rd_valid` in NREQ — per-requester read request.
- `rd_addr` in NREQ*AW — packed read addresses.
- `rd_ready` out NREQ — one-hot read grant (combinational).
- `rsp_valid` out NREQ — one-hot read-response strobe.
- `rsp_data` out DW — read data, shared by all requesters.
- `wea` out 1, `addra` out AW, `dina` out DW — RAM write port.
- `reb` out 1, `addrb` out AW — RAM read port.
- `doutb` in DW — RAM read data.

## Operation
- Handshake: a transfer for requester i occurs when `*_valid[i] & *_ready[i]` is high at the `clk` rising edge.
  - Requesters hold valid and payload until ready.
  - `ready` never depends on the requester's own `ready`.
- Write arbiter, round-robin:
  - Priority starts at `wptr+1` mod NREQ.
  - The first active `wr_valid` gets `wr_ready`.
  - `wptr` loads the granted index on a grant; otherwise it holds.
- Read arbiter: identical to the write arbiter, with its own pointer `rptr`, independent of the write side.
- Pointers after reset are NREQ-1, so requester 0 has top priority on the first cycle.
- RAM command registers:
  - On a write grant: `wea`=1, `addra`/`dina` = winner's payload, one cycle later.
  - With no write grant: `wea`=0; `addra`/`dina` hold their last value.
  - The read side works the same way for `reb`/`addrb`.
- Response tracking:
  - A pipeline of depth `RD_LAT` carries {valid, requester index} alongside each issued read.
  - At the output, `rsp_valid[idx]`=1 and `rsp_data`=`doutb`.
- No response backpressure: the requester must accept `rsp_valid` whenever it is asserted.
- An unserved requester waits at most NREQ-1 grants on that port; starvation is impossible.
- Reset mid-operation:
  - Pending responses in the pipeline are discarded; no `rsp_valid` follows reset.
  - Writes already registered to the RAM complete.
- Reset values: `wr_ready`=0, `rd_ready`=0, `rsp_valid`=0, `rsp_data`=0, `wea`=0, `reb`=0, `addra`=0, `dina`=0, `addrb`=0.
  - `ready` is forced low while `rst`=1.

## Timing
- Write: handshake in cycle N → `wea`=1 in cycle N+1 → data stored at the cycle N+1 edge.
- Read: handshake in cycle N → `reb`=1 in cycle N+1 → `rsp_valid`/`rsp_data` in cycle N+1+RD_LAT. With RD_LAT=1 this is N+2.
- Throughput: one write and one read per cycle sustained. Back-to-back grants to the same requester are allowed only when no other requester is requesting.
- `rsp_data` is a combinational pass-through of `doutb`; `rsp_valid` is registered.

## Configuration
- Macro: `SDP_ARB_RAW_HOLD_EN`.
- Defined:
  - A read candidate whose address equals the write address granted in the same cycle is suppressed for that cycle; `rd_ready`=0 for it.
  - `rptr` does not advance, and no other read is granted that cycle.
  - The read is retried the following cycle, so read-after-write returns the new data.
- Undefined:
  - Read and write arbitration are fully independent.
  - A same-address read returns the RAM's pre-write contents. Callers must avoid this case.

## Structure
- Package `sdp_arb_pkg`:
  - `localparam int RD_LAT_MAX = 3`.
  - Typedef `rsp_tag_t` = struct {logic vld; logic [2:0] idx;}.
  - Function `rr_pick(req, ptr)` returning the winning index.
- Sub-module `rr_arbiter` (parameter NREQ; ports `clk`, `rst`, `req`, `gnt`, `gnt_idx`) holds the pointer. It is instantiated twice: write and read.
- Top level contains payload muxes, RAM command registers, the optional RAW compare, and the response tag pipeline.

## Test plan
Bench configuration: NREQ=2, AW=4, DW=4, RD_LAT=1, RAM instantiated with `clka`=`clkb`=`clk`.

1. Reset: `rst`=1 for 3 cycles with all valids high → all outputs 0. After release, requester 0 gets the first grant on both ports.
2. Contention: both `wr_valid`=1 continuously for 8 cycles, payloads addresses 0..7 → grants alternate 0,1,0,1…; `wea` high 8 consecutive cycles starting 1 cycle after the first grant.
3. Fill and readback: write address i with data i+1 for i=0..7, then both requesters read addresses 0..7 → each response arrives 2 cycles after its handshake on the correct `rsp_valid` bit with data i+1.
4. Single requester: only requester 1 reads continuously → `rd_ready[1]`=1 every cycle, with no idle cycles.
5. Reset during reads: assert `rst` 1 cycle after a read handshake → no `rsp_valid` appears in the following 3 cycles.
6. RAW collision (`SDP_ARB_RAW_HOLD_EN` defined): write addr 5 data 9 and read addr 5 in the same cycle → read granted 1 cycle later; response data 9. Without the macro: both granted together, response returns the old contents.
